// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding/stall controller.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned TNEW_W = 2;

  // Forward-select codes shared by the D, E and M muxes
  localparam logic [2:0] FWD_RF = 3'd0;
  localparam logic [2:0] FWD_W  = 3'd1;
  localparam logic [2:0] FWD_M  = 3'd2;
  localparam logic [2:0] FWD_E  = 3'd3;

  // Operand not consumed by this instruction
  localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // Register 0 is hardwired, so it never matches a producer
  function automatic logic slot_match(slot_t s, logic [REG_AW-1:0] r);
    return (r != '0) && (s.a3 == r);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// One pipeline tracking slot {a3, tnew}: bubble load and saturating tnew decrement.
module hazard_slot
  import hazard_pkg::*;
#(
  parameter bit Decrement = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble_i,
  input  slot_t slot_i,
  output slot_t slot_o
);

  slot_t slot_d, slot_q;

  // Next-state: pass through, age tnew by one cycle, or squash into a bubble
  always_comb begin
    slot_d = slot_i;
    if (Decrement && (slot_i.tnew != '0)) begin
      slot_d.tnew = slot_i.tnew - 1'b1;
    end
    if (bubble_i) begin
      slot_d = SLOT_BUBBLE;
    end
  end

  // Slot register, cleared to a bubble on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= SLOT_BUBBLE;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding-select and stall generation for the 5-stage core.
// Optional feature: HAZARD_MDU_STALL_EN adds multiply/divide busy stalling.
module hazard_fwd_ctrl
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [TNEW_W-1:0] tuse_rs_d,
  input  logic [TNEW_W-1:0] tuse_rt_d,
  input  logic [REG_AW-1:0] a3_d,
  input  logic [TNEW_W-1:0] tnew_d,
`ifdef HAZARD_MDU_STALL_EN
  input  logic              md_use_d,
  input  logic              md_busy_e,
  input  logic              md_start_e,
`endif
  output logic              stall,
  output logic [2:0]        frsd,
  output logic [2:0]        frtd,
  output logic [2:0]        frse,
  output logic [2:0]        frte,
  output logic [2:0]        frtm
);

  slot_t slot_e, slot_m, slot_w, slot_in;
  logic [REG_AW-1:0] rs_e_q, rt_e_q, rt_m_q;
  logic reg_stall;

  assign slot_in = '{a3: a3_d, tnew: tnew_d};

  // E loads the D instruction undecremented; a stall squashes it into a bubble
  hazard_slot #(.Decrement(1'b0)) u_slot_e (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (stall),
    .slot_i   (slot_in),
    .slot_o   (slot_e)
  );

  hazard_slot #(.Decrement(1'b1)) u_slot_m (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .slot_i   (slot_e),
    .slot_o   (slot_m)
  );

  hazard_slot #(.Decrement(1'b1)) u_slot_w (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .slot_i   (slot_m),
    .slot_o   (slot_w)
  );

  // Source addresses following the instruction into E and M
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_e_q <= '0;
      rt_e_q <= '0;
      rt_m_q <= '0;
    end else begin
      rs_e_q <= stall ? '0 : rs_d;
      rt_e_q <= stall ? '0 : rt_d;
      rt_m_q <= rt_e_q;
    end
  end

  function automatic logic needs_stall(logic [REG_AW-1:0] r, logic [TNEW_W-1:0] tuse,
                                       slot_t e, slot_t m);
    logic pending;
    pending = (slot_match(e, r) && (tuse < e.tnew)) || (slot_match(m, r) && (tuse < m.tnew));
    return (tuse != TUSE_NONE) && pending;
  endfunction

  function automatic logic [2:0] d_sel(logic [REG_AW-1:0] r, slot_t e, slot_t m, slot_t w);
    if (slot_match(e, r) && (e.tnew == '0)) return FWD_E;
    if (slot_match(m, r) && (m.tnew == '0)) return FWD_M;
    if (slot_match(w, r))                   return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [2:0] e_sel(logic [REG_AW-1:0] r, slot_t m, slot_t w);
    if (slot_match(m, r) && (m.tnew == '0)) return FWD_M;
    if (slot_match(w, r))                   return FWD_W;
    return FWD_RF;
  endfunction

  // Stall and forward selects, combinational from tracked state and D inputs
  always_comb begin
    reg_stall = needs_stall(rs_d, tuse_rs_d, slot_e, slot_m) ||
                needs_stall(rt_d, tuse_rt_d, slot_e, slot_m);
`ifdef HAZARD_MDU_STALL_EN
    stall = reg_stall || (md_use_d && (md_busy_e || md_start_e));
`else
    stall = reg_stall;
`endif
    frsd = d_sel(rs_d, slot_e, slot_m, slot_w);
    frtd = d_sel(rt_d, slot_e, slot_m, slot_w);
    frse = e_sel(rs_e_q, slot_m, slot_w);
    frte = e_sel(rt_e_q, slot_m, slot_w);
    frtm = slot_match(slot_w, rt_m_q) ? FWD_W : FWD_RF;
  end

endmodule
